axi_block_master: RTL and testbench



---
 rtl/axi_pkg.sv | 19 +
 rtl/axi_beat_counter.sv | 29 ++
 rtl/axi_block_master.sv | 209 ++++++++++++++++++++
 tb/tb_axi_block_master.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared types and AXI4 encodings for the cache-line burst master.
package axi_pkg;

  localparam int         BEATS          = 8;
  localparam logic [7:0] AXI_LEN        = 8'd7;
  localparam logic [2:0] AXI_SIZE_64    = 3'b011;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_AW,
    ST_W,
    ST_B
  } state_t;

endpackage

// File: rtl/axi_beat_counter.sv
// 3-bit beat index shared by the read and write data phases.
module axi_beat_counter
  import axi_pkg::*;
(
  input  logic       clk,
  input  logic       arstn,
  input  logic       clr,
  input  logic       inc,
  output logic [2:0] count,
  output logic       last
);

  logic [2:0] count_reg;

  // Wraps 7->0 naturally; the FSM only lets that happen on the final beat.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc) begin
      count_reg <= count_reg + 3'd1;
    end
  end

  assign count = count_reg;
  assign last  = (count_reg == 3'(BEATS - 1));

endmodule

// File: rtl/axi_block_master.sv
// Cache-line <-> 8-beat AXI4 INCR burst master, one transaction in flight.
// Optional AXI_RESP_CHECK_EN adds a sticky o_resp_err for non-OKAY responses.
module axi_block_master
  import axi_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 64,
  parameter int BLOCK_W = 512
) (
  input  logic               clk,
  input  logic               arstn,
  input  logic               i_start_read,
  input  logic               i_start_write,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [BLOCK_W-1:0] i_data_write,
  output logic [BLOCK_W-1:0] o_data_read,
  output logic               o_read_last,
  output logic               o_b_resp,
  output logic               o_busy,
  output logic [ADDR_W-1:0]  o_araddr,
  output logic [7:0]         o_arlen,
  output logic [2:0]         o_arsize,
  output logic [1:0]         o_arburst,
  output logic               o_arvalid,
  input  logic               i_arready,
  input  logic [DATA_W-1:0]  i_rdata,
  input  logic [1:0]         i_rresp,
  input  logic               i_rlast,
  input  logic               i_rvalid,
  output logic               o_rready,
  output logic [ADDR_W-1:0]  o_awaddr,
  output logic [7:0]         o_awlen,
  output logic [2:0]         o_awsize,
  output logic [1:0]         o_awburst,
  output logic               o_awvalid,
  input  logic               i_awready,
  output logic [DATA_W-1:0]  o_wdata,
  output logic [7:0]         o_wstrb,
  output logic               o_wlast,
  output logic               o_wvalid,
  input  logic               i_wready,
  input  logic [1:0]         i_bresp,
  input  logic               i_bvalid,
  output logic               o_bready
`ifdef AXI_RESP_CHECK_EN
  ,
  output logic               o_resp_err
`endif
);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic              read_last_reg;
  logic              b_resp_reg;
  logic              load_wr, load_rd;
  logic              cnt_clr, cnt_inc;
  logic [2:0]        cnt;
  logic              cnt_last;
  logic              rd_take, b_take;
  logic [DATA_W-1:0] wbeat_vec [BEATS];

  axi_beat_counter u_beat_counter (
    .clk   (clk),
    .arstn (arstn),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .count (cnt),
    .last  (cnt_last)
  );

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load_wr    = 1'b0;
    load_rd    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    o_arvalid  = 1'b0;
    o_rready   = 1'b0;
    o_awvalid  = 1'b0;
    o_wvalid   = 1'b0;
    o_bready   = 1'b0;
    case (state_reg)
      // Write-back wins a tie; the dropped read is re-issued by the control unit.
      ST_IDLE: begin
        if (i_start_write) begin
          load_wr    = 1'b1;
          state_next = ST_AW;
        end else if (i_start_read) begin
          load_rd    = 1'b1;
          state_next = ST_AR;
        end
      end
      ST_AR: begin
        o_arvalid = 1'b1;
        if (i_arready) begin
          cnt_clr    = 1'b1;
          state_next = ST_R;
        end
      end
      ST_R: begin
        o_rready = 1'b1;
        if (i_rvalid) begin
          cnt_inc = 1'b1;
          if (cnt_last) state_next = ST_IDLE;
        end
      end
      ST_AW: begin
        o_awvalid = 1'b1;
        if (i_awready) begin
          cnt_clr    = 1'b1;
          state_next = ST_W;
        end
      end
      ST_W: begin
        o_wvalid = 1'b1;
        if (i_wready) begin
          cnt_inc = 1'b1;
          if (cnt_last) state_next = ST_B;
        end
      end
      ST_B: begin
        o_bready = 1'b1;
        if (i_bvalid) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign rd_take = o_rready && i_rvalid;
  assign b_take  = o_bready && i_bvalid;

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      addr_reg      <= '0;
      read_last_reg <= 1'b0;
      b_resp_reg    <= 1'b0;
    end else begin
      if (load_wr || load_rd) addr_reg <= {i_addr[ADDR_W-1:6], 6'b0};
      // Completion is decided by the beat count; i_rlast is not trusted.
      read_last_reg <= rd_take && cnt_last;
      b_resp_reg    <= b_take;
    end
  end

  for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
    logic [DATA_W-1:0] wbeat_reg;
    logic [DATA_W-1:0] rbeat_reg;

    always_ff @(posedge clk or negedge arstn) begin
      if (!arstn) begin
        wbeat_reg <= '0;
        rbeat_reg <= '0;
      end else begin
        if (load_wr) wbeat_reg <= i_data_write[gi*DATA_W +: DATA_W];
        if (rd_take && (cnt == 3'(gi))) rbeat_reg <= i_rdata;
      end
    end

    assign wbeat_vec[gi]                     = wbeat_reg;
    assign o_data_read[gi*DATA_W +: DATA_W]  = rbeat_reg;
  end

  assign o_wdata     = wbeat_vec[cnt];
  assign o_wlast     = (state_reg == ST_W) && cnt_last;
  assign o_wstrb     = 8'hFF;
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_read_last = read_last_reg;
  assign o_b_resp    = b_resp_reg;

  assign o_araddr  = addr_reg;
  assign o_awaddr  = addr_reg;
  assign o_arlen   = AXI_LEN;
  assign o_awlen   = AXI_LEN;
  assign o_arsize  = AXI_SIZE_64;
  assign o_awsize  = AXI_SIZE_64;
  assign o_arburst = AXI_BURST_INCR;
  assign o_awburst = AXI_BURST_INCR;

`ifdef AXI_RESP_CHECK_EN
  logic resp_err_reg;

  // Sticky until reset; the transfer itself still completes normally.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      resp_err_reg <= 1'b0;
    end else if ((rd_take && (i_rresp != AXI_RESP_OKAY)) ||
                 (b_take && (i_bresp != AXI_RESP_OKAY))) begin
      resp_err_reg <= 1'b1;
    end
  end

  assign o_resp_err = resp_err_reg;

  logic unused_inputs;
  assign unused_inputs = ^{i_rlast, i_addr[5:0]};
`else
  logic unused_inputs;
  assign unused_inputs = ^{i_rlast, i_rresp, i_bresp, i_addr[5:0]};
`endif

endmodule

// File: tb/tb_axi_block_master.sv
// Self-checking bench for axi_block_master: vector table, hand-written corner
// sequences and randomized bursts against a line-level reference model.
module tb_axi_block_master;

  localparam int DATA_W  = 64;
  localparam int ADDR_W  = 64;
  localparam int BLOCK_W = 512;

  logic               clk = 1'b0;
  logic               arstn = 1'b0;
  logic               i_start_read = 1'b0, i_start_write = 1'b0;
  logic [ADDR_W-1:0]  i_addr = '0;
  logic [BLOCK_W-1:0] i_data_write = '0;
  logic [BLOCK_W-1:0] o_data_read;
  logic               o_read_last, o_b_resp, o_busy;
  logic [ADDR_W-1:0]  o_araddr, o_awaddr;
  logic [7:0]         o_arlen, o_awlen, o_wstrb;
  logic [2:0]         o_arsize, o_awsize;
  logic [1:0]         o_arburst, o_awburst;
  logic               o_arvalid, o_rready, o_awvalid, o_wlast, o_wvalid, o_bready;
  logic               i_arready = 1'b0, i_rlast = 1'b0, i_rvalid = 1'b0;
  logic               i_awready = 1'b0, i_wready = 1'b0, i_bvalid = 1'b0;
  logic [DATA_W-1:0]  i_rdata = '0;
  logic [DATA_W-1:0]  o_wdata;
  logic [1:0]         i_rresp = 2'b00, i_bresp = 2'b00;
`ifdef AXI_RESP_CHECK_EN
  logic               o_resp_err;
`endif

  axi_block_master #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dut (
    .clk(clk), .arstn(arstn),
    .i_start_read(i_start_read), .i_start_write(i_start_write),
    .i_addr(i_addr), .i_data_write(i_data_write), .o_data_read(o_data_read),
    .o_read_last(o_read_last), .o_b_resp(o_b_resp), .o_busy(o_busy),
    .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize), .o_arburst(o_arburst),
    .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rlast(i_rlast), .i_rvalid(i_rvalid),
    .o_rready(o_rready),
    .o_awaddr(o_awaddr), .o_awlen(o_awlen), .o_awsize(o_awsize), .o_awburst(o_awburst),
    .o_awvalid(o_awvalid), .i_awready(i_awready),
    .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast), .o_wvalid(o_wvalid),
    .i_wready(i_wready),
    .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready)
`ifdef AXI_RESP_CHECK_EN
    , .o_resp_err(o_resp_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [BLOCK_W-1:0] exp_line = '0;   // model: last completed refill line
  logic               exp_err = 1'b0;  // model: sticky response error

  function automatic void check(input string name, input logic [511:0] act,
                                input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endfunction

  function automatic logic [63:0] align(input logic [63:0] a);
    return a & ~64'd63;
  endfunction

  function automatic logic [511:0] counting_line(input logic [63:0] base,
                                                 input logic [63:0] stepv);
    logic [511:0] l;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = base + 64'(k) * stepv;
    return l;
  endfunction

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input int k);
    for (int i = 0; i < k; i++) begin
      step();
      check("idle_pulses", {o_read_last, o_b_resp}, 2'b00);
      check("idle_no_req", {o_arvalid, o_awvalid, o_busy}, 3'b000);
      check("idle_data_read", o_data_read, exp_line);
`ifdef AXI_RESP_CHECK_EN
      check("idle_resp_err", o_resp_err, exp_err);
`endif
    end
  endtask

  // Drives one refill as an AXI slave; start is presented in the current cycle.
  task automatic read_txn(input logic [63:0] addr, input logic [511:0] line, input bit zw,
                          input int err_beat, input logic [63:0] exp_addr, input int exp_lat);
    int n, beat;
    bit done, hs, rv;
    n = 0; beat = 0; done = 0;
    i_addr = addr;
    i_start_read = 1'b1;
    step();
    i_start_read = 1'b0;
    n = 1;
    check("ar_issue", o_arvalid, 1'b1);
    check("prev_pulse_width", {o_read_last, o_b_resp}, 2'b00);
    while (!done && n < 300) begin
      if (o_read_last) begin
        done = 1;
      end else begin
        check("busy_rd", o_busy, 1'b1);
        if (o_awvalid) check("no_aw_on_read", o_awvalid, 1'b0);
        if (o_arvalid) begin
          check("araddr", o_araddr, exp_addr);
          check("ar_attrs", {o_arlen, o_arsize, o_arburst}, {8'd7, 3'b011, 2'b01});
        end
        i_arready = zw ? 1'b1 : ($urandom_range(0, 3) != 0);
        rv        = zw ? 1'b1 : ($urandom_range(0, 3) != 0);
        i_rvalid  = o_rready && rv;
        i_rdata   = line[(beat % 8)*64 +: 64];
        i_rresp   = (beat == err_beat) ? 2'b10 : 2'b00;
        i_rlast   = zw ? (beat == 7) : 1'($urandom_range(0, 1));
        hs        = o_rready && rv;
        step();
        n++;
        if (hs) begin
          if (i_rresp != 2'b00) exp_err = 1'b1;
          beat++;
        end
      end
    end
    i_arready = 1'b0; i_rvalid = 1'b0; i_rlast = 1'b0; i_rresp = 2'b00;
    check("read_done", done, 1'b1);
    if (done) begin
      exp_line = line;
      check("read_beats", beat, 8);
      check("read_line", o_data_read, exp_line);
      check("busy_at_read_last", o_busy, 1'b0);
      if (exp_lat > 0) check("read_latency", n, exp_lat);
    end
  endtask

  // Drives one write-back; optionally raises start_read alongside or mid-burst.
  task automatic write_txn(input logic [63:0] addr, input logic [511:0] line, input bit zw,
                           input bit also_read, input bit poke_read, input logic [1:0] bresp,
                           input logic [63:0] exp_addr, input int exp_lat);
    int n, beat, b_hs_n;
    bit done, hs, wr, bv, poked;
    n = 0; beat = 0; done = 0; b_hs_n = -10; poked = 0;
    i_addr = addr;
    i_data_write = line;
    i_start_write = 1'b1;
    i_start_read = also_read;
    step();
    i_start_write = 1'b0;
    i_start_read = 1'b0;
    n = 1;
    check("aw_issue", {o_awvalid, o_arvalid}, 2'b10);
    check("prev_pulse_width", {o_read_last, o_b_resp}, 2'b00);
    while (!done && n < 300) begin
      i_start_read = 1'b0;
      if (o_b_resp) begin
        done = 1;
      end else begin
        check("busy_wr", o_busy, 1'b1);
        if (o_arvalid) check("no_ar_on_write", o_arvalid, 1'b0);
        if (o_awvalid) begin
          check("awaddr", o_awaddr, exp_addr);
          check("aw_attrs", {o_awlen, o_awsize, o_awburst}, {8'd7, 3'b011, 2'b01});
        end
        if (o_wvalid) begin
          check("wdata", o_wdata, line[(beat % 8)*64 +: 64]);
          check("wlast", o_wlast, beat == 7);
          check("wstrb", o_wstrb, 8'hFF);
          if (poke_read && !poked && beat == 3) begin
            i_start_read = 1'b1;
            poked = 1;
          end
        end
        i_awready = zw ? 1'b1 : ($urandom_range(0, 3) != 0);
        wr        = zw ? 1'b1 : ($urandom_range(0, 2) != 0);
        i_wready  = wr;
        bv        = zw ? 1'b1 : ($urandom_range(0, 2) != 0);
        i_bvalid  = o_bready && bv;
        i_bresp   = bresp;
        hs        = o_wvalid && wr;
        if (o_bready && bv) b_hs_n = n;
        step();
        n++;
        if (hs) beat++;
      end
    end
    i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0; i_start_read = 1'b0; i_bresp = 2'b00;
    check("write_done", done, 1'b1);
    if (done) begin
      if (bresp != 2'b00) exp_err = 1'b1;
      check("write_beats", beat, 8);
      check("bresp_timing", n, b_hs_n + 1);
      check("data_read_kept", o_data_read, exp_line);
      check("busy_at_b_resp", o_busy, 1'b0);
      if (exp_lat > 0) check("write_latency", n, exp_lat);
    end
  endtask

  typedef struct {
    bit          is_write;
    logic [63:0] addr;
    logic [63:0] base;
    logic [63:0] stepv;
    bit          zw;
    logic [63:0] exp_addr;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [511:0] line;
    logic [63:0]  addr;
    int           beat;

    vecs[0] = '{0, 64'h0000_0000_1000_0047, 64'h11, 64'h11, 1, 64'h0000_0000_1000_0040, 10};
    vecs[1] = '{1, 64'h0000_0000_2000_007F, 64'h1, 64'h1, 1, 64'h0000_0000_2000_0040, 11};
    vecs[2] = '{1, 64'h0000_0000_3000_0000, 64'h1, 64'h1, 0, 64'h0000_0000_3000_0000, 0};
    vecs[3] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hA5A5_0000_0000_0001, 64'h3, 1,
                64'hFFFF_FFFF_FFFF_FFC0, 10};
    vecs[4] = '{1, 64'h0, 64'hDEAD, 64'h100, 1, 64'h0, 11};
    vecs[5] = '{0, 64'h0000_0000_0000_003F, 64'h7, 64'h7, 0, 64'h0, 0};

    // Power-on reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready, o_busy,
                       o_read_last, o_b_resp, o_wlast}, 9'b0);
    check("rst_addr", {o_araddr, o_awaddr}, 128'b0);
    check("rst_wdata", o_wdata, 64'b0);
    check("rst_data_read", o_data_read, 512'b0);
`ifdef AXI_RESP_CHECK_EN
    check("rst_resp_err", o_resp_err, 1'b0);
`endif
    arstn = 1'b1;
    idle_check(2);

    for (int i = 0; i < 6; i++) begin
      line = counting_line(vecs[i].base, vecs[i].stepv);
      if (vecs[i].is_write)
        write_txn(vecs[i].addr, line, vecs[i].zw, 0, 0, 2'b00, vecs[i].exp_addr, vecs[i].exp_lat);
      else
        read_txn(vecs[i].addr, line, vecs[i].zw, -1, vecs[i].exp_addr, vecs[i].exp_lat);
      idle_check(2);
    end

    // Simultaneous starts: only the write runs, no AR afterwards.
    write_txn(64'h5000_0008, counting_line(64'h1, 64'h1), 1, 1, 0, 2'b00, 64'h5000_0000, 11);
    idle_check(4);

    // start_read during W is ignored.
    write_txn(64'h6000_00C0, rand_line(), 0, 0, 1, 2'b00, 64'h6000_00C0, 0);
    idle_check(4);

    // Back-to-back: next start issued in the completion-pulse cycle.
    read_txn(64'h7000_0100, rand_line(), 1, -1, 64'h7000_0100, 10);
    write_txn(64'h7000_0140, rand_line(), 1, 0, 0, 2'b00, 64'h7000_0140, 11);
    read_txn(64'h7000_0180, rand_line(), 1, -1, 64'h7000_0180, 10);
    idle_check(1);

    // Reset in the middle of beat 4 of a refill.
    line = rand_line();
    i_addr = 64'h4000_0010;
    i_start_read = 1'b1;
    step();
    i_start_read = 1'b0;
    i_arready = 1'b1;
    step();
    i_arready = 1'b0;
    beat = 0;
    while (beat < 4) begin
      i_rvalid = 1'b1;
      i_rdata = line[beat*64 +: 64];
      step();
      beat++;
    end
    i_rdata = line[4*64 +: 64];
    #2 arstn = 1'b0;
    step();
    check("midrst_ctrl", {o_arvalid, o_awvalid, o_wvalid, o_rready, o_bready, o_busy,
                          o_read_last, o_b_resp, o_wlast}, 9'b0);
    check("midrst_addr", {o_araddr, o_awaddr}, 128'b0);
    check("midrst_data_read", o_data_read, 512'b0);
    i_rvalid = 1'b0;
    arstn = 1'b1;
    exp_line = '0;
    exp_err = 1'b0;
    idle_check(3);
    read_txn(64'h4000_0010, line, 1, -1, 64'h4000_0000, 10);
    idle_check(1);

`ifdef AXI_RESP_CHECK_EN
    // SLVERR on beat 3 sets the sticky flag; later OKAY traffic leaves it set.
    read_txn(64'h8000_0000, rand_line(), 1, 3, 64'h8000_0000, 10);
    idle_check(1);
    check("resp_err_set", o_resp_err, 1'b1);
    read_txn(64'h8000_0040, rand_line(), 0, -1, 64'h8000_0040, 0);
    write_txn(64'h8000_0080, rand_line(), 0, 0, 0, 2'b00, 64'h8000_0080, 0);
    idle_check(1);
    check("resp_err_sticky", o_resp_err, 1'b1);
`endif

    // Randomized traffic against the line-level model.
    for (int t = 0; t < 24; t++) begin
      addr = {$urandom, $urandom};
      line = rand_line();
      if ($urandom_range(0, 1) == 1)
        write_txn(addr, line, ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
                  ($urandom_range(0, 2) == 0), 2'b00, align(addr), 0);
      else
        read_txn(addr, line, ($urandom_range(0, 3) == 0), -1, align(addr), 0);
      if ($urandom_range(0, 1) == 1) idle_check($urandom_range(1, 3));
    end
    idle_check(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
